// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- load/store port between the CPU (master) and the
// data-memory responder (slave).
//   req, we, addr, wdata : CPU -> memory request and payload
//   rdata, ack, err      : memory -> CPU completion
//   busy                 : memory -> CPU, transfer in progress
// Optional macro DMEM_PARITY_EN adds inject_par (CPU -> memory), which flips
// the parity bit written by the next store.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;
   logic        err;
   logic        busy;
`ifdef DMEM_PARITY_EN
   logic        inject_par;

   modport master (output req, we, addr, wdata, inject_par,
                   input  rdata, ack, err, busy);
   modport slave  (input  req, we, addr, wdata, inject_par,
                   output rdata, ack, err, busy);
`else
   modport master (output req, we, addr, wdata,
                   input  rdata, ack, err, busy);
   modport slave  (input  req, we, addr, wdata,
                   output rdata, ack, err, busy);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- data-memory slave for the 16-bit MIPS CPU load/store port.
// Accepts one request at a time, waits WAIT_CYCLES, then completes the store
// or load and holds ack until the CPU drops req (four-phase handshake).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : dmem_responder_if.slave (req/we/addr/wdata in, rdata/ack/err/busy out)
// Optional macro DMEM_PARITY_EN: 17-bit words with even parity, parity
// mismatch on load raises err, bus.inject_par corrupts the next stored parity.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no transfer; waiting for req
// S_WAIT | request latched; counting down wait states
// S_ACK  | transfer done; ack/err/rdata valid until req drops
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;
`ifdef DMEM_PARITY_EN
   localparam int WORD_W = 17;
`else
   localparam int WORD_W = 16;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t              state, state_nxt;
   logic                accept, finish, done;
   logic [3:0]          wait_cnt;
   logic                we_q;
   logic [15:0]         addr_q;
   logic [15:0]         wdata_q;
   logic                err_q;
   logic [15:0]         rdata_q;
   logic [WORD_W-1:0]   mem [DEPTH];
   logic [WORD_W-1:0]   mem_rd;
   logic [ADDR_W-1:0]   word_idx;
   logic                addr_err;
   logic                xfer_err;
   logic [15:0]         word_num;
`ifdef DMEM_PARITY_EN
   logic                inj_q;
   logic                par_err;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // WAIT always lasts at least one edge, so ack rises WAIT_CYCLES+1 edges
   // after the accepting edge, including for WAIT_CYCLES=0.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: if (bus.req) begin
            state_nxt = S_WAIT;
            accept    = 1'b1;
         end
         S_WAIT: if (wait_cnt == 4'd0) begin
            state_nxt = S_ACK;
            finish    = 1'b1;
         end
         S_ACK: if (!bus.req) begin
            state_nxt = S_IDLE;
            done      = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- address check ----------------
   // Out-of-range words are rejected, never aliased by truncation.
   assign word_num = {1'b0, addr_q[15:1]};
   assign word_idx = addr_q[ADDR_W:1];
   assign addr_err = addr_q[0] | (32'(word_num) >= 32'(DEPTH));
   assign mem_rd   = mem[word_idx];

`ifdef DMEM_PARITY_EN
   assign par_err  = ^mem_rd;
   assign xfer_err = addr_err | (!we_q & par_err);
`else
   assign xfer_err = addr_err;
`endif

   // ---------------- datapath ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 4'd0;
         we_q     <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 16'h0000;
         err_q    <= 1'b0;
         rdata_q  <= 16'h0000;
`ifdef DMEM_PARITY_EN
         inj_q    <= 1'b0;
`endif
      end else begin
         if (accept) begin
            wait_cnt <= 4'(WAIT_CYCLES);
            we_q     <= bus.we;
            addr_q   <= bus.addr;
            wdata_q  <= bus.wdata;
`ifdef DMEM_PARITY_EN
            inj_q    <= bus.inject_par;
`endif
         end else if (state == S_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (finish) begin
            err_q <= xfer_err;
            if (addr_err)  rdata_q <= 16'h0000;
            else if (we_q) rdata_q <= wdata_q;
            else           rdata_q <= mem_rd[15:0];
         end else if (done) begin
            err_q <= 1'b0;
         end
      end
   end

   // Array is deliberately not reset; a store commits only on ACK entry, so
   // a reset during WAIT leaves it untouched.
   always_ff @(posedge clk) begin
      if (finish && we_q && !addr_err) begin
`ifdef DMEM_PARITY_EN
         mem[word_idx] <= {(^wdata_q) ^ inj_q, wdata_q};
`else
         mem[word_idx] <= wdata_q;
`endif
      end
   end

   assign bus.ack   = (state == S_ACK);
   assign bus.busy  = (state != S_IDLE);
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_z;
   always #5 clk = ~clk;

   dmem_responder_if bus_a ();
   dmem_responder_if bus_z ();

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut_z (
      .clk   (clk),
      .reset (rst_z),
      .bus   (bus_z.slave)
   );

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic [15:0] model [32:39];

   // Runs one complete four-phase transfer; starts and ends at a negedge.
   task automatic xfer(input bit sel, input bit w, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] rd,
                       output logic e, output int lat, output bit to);
      if (!sel) begin
         bus_a.req = 1'b1; bus_a.we = w; bus_a.addr = a; bus_a.wdata = d;
      end else begin
         bus_z.req = 1'b1; bus_z.we = w; bus_z.addr = a; bus_z.wdata = d;
      end
      @(posedge clk);
      lat = 0;
      to  = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if ((!sel && bus_a.ack) || (sel && bus_z.ack)) begin
            lat = i;
            to  = 1'b0;
            break;
         end
      end
      rd = sel ? bus_z.rdata : bus_a.rdata;
      e  = sel ? bus_z.err   : bus_a.err;
      if (!sel) bus_a.req = 1'b0;
      else      bus_z.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_and_check(input string nm, input bit sel, input bit w,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic [15:0] exp_rd, input logic exp_e,
                                input int exp_lat);
      logic [15:0] rd;
      logic        e;
      int          lat;
      bit          to;
      exp_t        ex;
      sb.push_back('{rdata: exp_rd, err: exp_e, lat: exp_lat});
      xfer(sel, w, a, d, rd, e, lat, to);
      ex = sb.pop_front();
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: no ack within 40 edges", nm);
      end else begin
         if (ex.lat >= 0) begin
            checks++;
            if (lat !== ex.lat) begin
               errors++;
               $display("FAIL %s latency: got %0d expected %0d", nm, lat, ex.lat);
            end
         end
         checks++;
         if (rd !== ex.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h expected %h", nm, rd, ex.rdata);
         end
         checks++;
         if (e !== ex.err) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", nm, e, ex.err);
         end
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_z = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 4;
      if ({bus_a.ack, bus_a.busy, bus_a.err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_a flags: ack/busy/err got %b expected 000",
                  {bus_a.ack, bus_a.busy, bus_a.err});
      end
      if (bus_a.rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_a rdata: got %h expected 0000", bus_a.rdata);
      end
      if ({bus_z.ack, bus_z.busy, bus_z.err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_z flags: ack/busy/err got %b expected 000",
                  {bus_z.ack, bus_z.busy, bus_z.err});
      end
      if (bus_z.rdata !== 16'h0000) begin
         errors++;
         $display("FAIL reset_z rdata: got %h expected 0000", bus_z.rdata);
      end
      rst_a = 1'b0;
      rst_z = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      run_and_check("t1_store", 1'b0, 1'b1, 16'h0004, 16'h0005, 16'h0005, 1'b0, 3);
      run_and_check("t1_load",  1'b0, 1'b0, 16'h0004, 16'hFFFF, 16'h0005, 1'b0, 3);
   endtask

   task automatic test_zero_wait();
      run_and_check("t2_store", 1'b1, 1'b1, 16'h0002, 16'h0007, 16'h0007, 1'b0, 1);
      run_and_check("t2_load",  1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0007, 1'b0, 1);
   endtask

   task automatic test_misaligned();
      run_and_check("t3_prep",  1'b0, 1'b1, 16'h0002, 16'h3C3C, 16'h3C3C, 1'b0, 3);
      run_and_check("t3_mis",   1'b0, 1'b1, 16'h0003, 16'hDEAD, 16'h0000, 1'b1, 3);
      run_and_check("t3_after", 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h3C3C, 1'b0, 3);
   endtask

   task automatic test_out_of_range();
      run_and_check("t4_word0", 1'b0, 1'b1, 16'h0000, 16'h1234, 16'h1234, 1'b0, -1);
      run_and_check("t4_oor",   1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000, 1'b1, 3);
      run_and_check("t4_oorst", 1'b0, 1'b1, 16'h07FF, 16'h9999, 16'h0000, 1'b1, -1);
      run_and_check("t4_top",   1'b0, 1'b1, 16'h07FE, 16'h4242, 16'h4242, 1'b0, -1);
      run_and_check("t4_chk0",  1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, -1);
   endtask

   task automatic test_hold_req();
      bit got = 1'b0;
      bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 16'h0020; bus_a.wdata = 16'hA5A5;
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus_a.ack) begin got = 1'b1; break; end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL t5 timeout: no ack within 40 edges");
      end
      bus_a.we = 1'b1; bus_a.addr = 16'h0022; bus_a.wdata = 16'h5A5A;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if ({bus_a.ack, bus_a.busy} !== 2'b11) begin
            errors++;
            $display("FAIL t5_hold%0d ack/busy: got %b expected 11", i,
                     {bus_a.ack, bus_a.busy});
         end
      end
      bus_a.req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks += 2;
      if ({bus_a.ack, bus_a.busy} !== 2'b00) begin
         errors++;
         $display("FAIL t5_drop ack/busy: got %b expected 00", {bus_a.ack, bus_a.busy});
      end
      if (bus_a.rdata !== 16'hA5A5) begin
         errors++;
         $display("FAIL t5_drop rdata kept: got %h expected a5a5", bus_a.rdata);
      end
      run_and_check("t5_load", 1'b0, 1'b0, 16'h0020, 16'h0000, 16'hA5A5, 1'b0, 3);
      run_and_check("t5_prep22", 1'b0, 1'b1, 16'h0022, 16'h0101, 16'h0101, 1'b0, -1);
   endtask

   task automatic test_reset_in_wait();
      run_and_check("t6_prep", 1'b0, 1'b1, 16'h0010, 16'h1111, 16'h1111, 1'b0, -1);
      bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 16'h0010; bus_a.wdata = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_a.busy !== 1'b1) begin
         errors++;
         $display("FAIL t6_wait busy: got %b expected 1", bus_a.busy);
      end
      rst_a = 1'b1;
      #1;
      checks++;
      if ({bus_a.ack, bus_a.busy} !== 2'b00) begin
         errors++;
         $display("FAIL t6_rst ack/busy: got %b expected 00", {bus_a.ack, bus_a.busy});
      end
      @(negedge clk);
      bus_a.req = 1'b0;
      rst_a = 1'b0;
      @(negedge clk);
      run_and_check("t6_load", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1111, 1'b0, 3);
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      int          w;
      for (int i = 32; i <= 39; i++) begin
         d = 16'($urandom);
         model[i] = d;
         run_and_check("b2b_st", 1'b0, 1'b1, 16'(i * 2), d, d, 1'b0, -1);
      end
      for (int i = 0; i < 12; i++) begin
         w = int'($urandom_range(32, 39));
         if ($urandom_range(0, 1) == 1) begin
            d = 16'($urandom);
            model[w] = d;
            run_and_check("b2b_st", 1'b0, 1'b1, 16'(w * 2), d, d, 1'b0, -1);
         end else begin
            run_and_check("b2b_ld", 1'b0, 1'b0, 16'(w * 2), 16'h0000, model[w], 1'b0, -1);
         end
      end
   endtask

   initial begin
      bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = 16'h0000; bus_a.wdata = 16'h0000;
      bus_z.req = 1'b0; bus_z.we = 1'b0; bus_z.addr = 16'h0000; bus_z.wdata = 16'h0000;
`ifdef DMEM_PARITY_EN
      bus_a.inject_par = 1'b0;
      bus_z.inject_par = 1'b0;
`endif
      rst_a = 1'b1;
      rst_z = 1'b1;
      @(negedge clk);
      test_reset();
      test_store_load();
      test_zero_wait();
      test_misaligned();
      test_out_of_range();
      test_hold_req();
      test_reset_in_wait();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
